// File: rtl/pwm_ddr_multi.sv
// pwm_ddr_multi: multi-channel DDR PWM with shared down-counter and double-buffered duties
module pwm_ddr_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 10,
    parameter int CH_BITS  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync,
    input  logic                wr_en,
    input  logic [CH_BITS-1:0]  wr_ch,
    input  logic [WIDTH:0]      wr_duty,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] inv,
    output logic [CHANNELS-1:0] pwm_d0,
    output logic [CHANNELS-1:0] pwm_d1,
    output logic                period_start
);
    localparam int LO = WIDTH / 2;

    logic [WIDTH-1:0]    r_cnt;
    logic [WIDTH:0]      r_pend [CHANNELS];
    logic [WIDTH:0]      r_act  [CHANNELS];
    logic [CHANNELS-1:0] w_lt_hi, w_eq_hi, w_lt_lo, w_eq_lo;
    logic [CHANNELS-1:0] r_lt_hi, r_eq_hi, r_lt_lo, r_eq_lo, r_h, r_en, r_inv;
    logic [CHANNELS-1:0] w_raw0, w_raw1;
    logic                r_ps1;
    logic                w_bnd;

    assign w_bnd = (r_cnt == '0) || sync;

    // Shared down-counter; sync forces a reload to the top of the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '1;
        else        r_cnt <= sync ? '1 : r_cnt - WIDTH'(1);
    end

    // Pending duties take writes; active duties load from pending only at boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_pend[i] <= '0;
                r_act[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_bnd) r_act[i] <= r_pend[i];
                if (wr_en && wr_ch == CH_BITS'(i)) r_pend[i] <= wr_duty;
            end
        end
    end

    // Split count-vs-N compare into high-field and low-field partials
    always_comb begin
        w_lt_hi = '0;
        w_eq_hi = '0;
        w_lt_lo = '0;
        w_eq_lo = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_lt_hi[i] = r_cnt[WIDTH-1:LO] <  r_act[i][WIDTH:LO+1];
            w_eq_hi[i] = r_cnt[WIDTH-1:LO] == r_act[i][WIDTH:LO+1];
            w_lt_lo[i] = r_cnt[LO-1:0]     <  r_act[i][LO:1];
            w_eq_lo[i] = r_cnt[LO-1:0]     == r_act[i][LO:1];
        end
    end

    // Stage 1: register partial compares, half-step bit, enable, polarity and period marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lt_hi <= '0;
            r_eq_hi <= '0;
            r_lt_lo <= '0;
            r_eq_lo <= '0;
            r_h     <= '0;
            r_en    <= '0;
            r_inv   <= '0;
            r_ps1   <= 1'b0;
        end else begin
            r_lt_hi <= w_lt_hi;
            r_eq_hi <= w_eq_hi;
            r_lt_lo <= w_lt_lo;
            r_eq_lo <= w_eq_lo;
            for (int i = 0; i < CHANNELS; i++) r_h[i] <= r_act[i][0];
            r_en    <= en;
            r_inv   <= inv;
            r_ps1   <= r_cnt == '1;
        end
    end

    // Combine partials: d1 is high while c < N, d0 also during the extra half-step
    always_comb begin
        w_raw1 = r_lt_hi | (r_eq_hi & r_lt_lo);
        w_raw0 = w_raw1 | (r_eq_hi & r_eq_lo & r_h);
    end

    // Stage 2: apply enable and polarity; disabled channels sit at the inactive level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_d0       <= '0;
            pwm_d1       <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_d0       <= (w_raw0 & r_en) ^ r_inv;
            pwm_d1       <= (w_raw1 & r_en) ^ r_inv;
            period_start <= r_ps1;
        end
    end
endmodule

// File: tb/tb_pwm_ddr_multi.sv
// tb_pwm_ddr_multi: directed and random checks of pwm_ddr_multi against a half-clock duty model
module tb_pwm_ddr_multi;
    logic       clk = 0, rst_n = 0, sync = 0, wr_en = 0;
    logic [1:0] wr_ch = 0;
    logic [4:0] wr_duty = 0;
    logic [3:0] en = 0, inv = 0;
    logic [3:0] d0, d1;
    logic       ps;
    logic [2:0] b_d0, b_d1;
    logic       b_ps;
    int n_chk = 0, n_fail = 0;
    int m_cnt;
    int m_pend[4];
    int m_act[4];
    logic [3:0] m_d0, m_d1, e_d0, e_d1;
    logic       m_ps, e_ps;

    pwm_ddr_multi #(.CHANNELS(4), .WIDTH(4), .CH_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .en(en), .inv(inv), .pwm_d0(d0), .pwm_d1(d1), .period_start(ps)
    );

    pwm_ddr_multi #(.CHANNELS(3), .WIDTH(4), .CH_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .en(en[2:0]), .inv(inv[2:0]), .pwm_d0(b_d0), .pwm_d1(b_d1), .period_start(b_ps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        m_cnt = 15;
        for (int c = 0; c < 4; c++) begin
            m_pend[c] = 0;
            m_act[c]  = 0;
        end
        m_d0 = 0; m_d1 = 0; m_ps = 0;
        e_d0 = 0; e_d1 = 0; e_ps = 0;
    endtask

    // One clock: the model consumes this cycle's inputs; a cycle's result shows two edges later
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            e_d0 = m_d0; e_d1 = m_d1; e_ps = m_ps;
            for (int c = 0; c < 4; c++) begin
                m_d0[c] = en[c] ? ((2 * m_cnt < m_act[c]) ^ inv[c]) : inv[c];
                m_d1[c] = en[c] ? ((2 * m_cnt + 1 < m_act[c]) ^ inv[c]) : inv[c];
            end
            m_ps = (m_cnt == 15);
            if (m_cnt == 0 || sync) for (int c = 0; c < 4; c++) m_act[c] = m_pend[c];
            if (wr_en) m_pend[wr_ch] = int'(wr_duty);
            m_cnt = sync ? 15 : (m_cnt + 15) % 16;
        end
        #1;
    endtask

    task automatic wr(input int ch, input int duty);
        wr_en = 1; wr_ch = 2'(ch); wr_duty = 5'(duty);
        tick();
        wr_en = 0;
    endtask

    task automatic skip_to(input int c);
        int k = 0;
        while (m_cnt != c && k < 40) begin tick(); k++; end
    endtask

    task automatic wait_ps();
        int k = 0;
        while (!ps && k < 40) begin tick(); k++; end
        if (!ps) chk("ps_timeout", 0, 1);
    endtask

    // Sum of high half-clocks of one channel over the next full period
    task automatic measure(input int ch, input int exp, input string name);
        int s;
        wait_ps();
        s = d0[ch] + d1[ch];
        for (int i = 0; i < 15; i++) begin
            tick();
            s += d0[ch] + d1[ch];
        end
        chk(name, s, exp);
    endtask

    task automatic hold_rst();
        rst_n = 0;
        mreset();
        #1;
        chk("async_rst", int'({d0, d1, ps}), 0);
        chk("async_rst_b", int'({b_d0, b_d1, b_ps}), 0);
        tick();
        rst_n = 1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("d0", d0, e_d0);
            chk("d1", d1, e_d1);
            chk("ps", ps, e_ps);
            chk("b_d0", b_d0, e_d0[2:0]);
            chk("b_d1", b_d1, e_d1[2:0]);
            chk("b_ps", b_ps, e_ps);
        end
    end

    initial begin
        mreset();
        inv = 4'hF;
        repeat (3) tick();
        chk("reset_out", int'({d0, d1, ps}), 0);
        inv = 0; en = 4'hF;
        rst_n = 1;
        wr(0, 6);
        skip_to(15);
        measure(0, 6, "t1_ch0");
        wr(1, 7); wr(2, 0); wr(3, 31);
        skip_to(15);
        measure(1, 7, "t2_ch1");
        measure(3, 31, "t2_ch3");
        measure(2, 0, "t2_ch2");
        wr(0, 8); wr(0, 2);
        skip_to(0);
        wr(0, 10);
        measure(0, 2, "t3_last_wins");
        measure(0, 10, "t3_boundary_wr");
        skip_to(12);
        wr(0, 4);
        skip_to(9);
        sync = 1;
        tick();
        sync = 0;
        tick();
        chk("t4_ps_early", ps, 0);
        tick();
        chk("t4_ps", ps, 1);
        measure(0, 4, "t4_sync_commit");
        en = 4'b1110; inv = 4'b0001;
        tick(); tick();
        chk("t5_idle_inv", int'({d1[0], d0[0]}), 3);
        en = 4'hF;
        wr(0, 6);
        skip_to(15);
        measure(0, 26, "t5_inverted");
        inv = 0;
        skip_to(7);
        hold_rst();
        measure(0, 0, "t6_zero_after_rst");
        wr(3, 20);
        skip_to(15);
        measure(3, 20, "t6_ch3");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) hold_rst();
            sync    = ($urandom_range(0, 29) == 0);
            wr_en   = ($urandom_range(0, 9) < 4);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_duty = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 19) == 0) en = 4'($urandom);
            if ($urandom_range(0, 19) == 0) inv = 4'($urandom);
            tick();
        end
        sync = 0; wr_en = 0;
        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
